// File: rtl/dice_result_capture.sv
// Captures the settled dice face after button release, shows it on the pip LEDs
// and offers it downstream over valid/ready. Optional per-face tallies: TALLY_EN.
module dice_result_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int COUNT_W       = 8,
    parameter int TALLY_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    output logic [2:0]         result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [6:0]         pips,
    output logic [COUNT_W-1:0] roll_count,
    output logic               err_invalid,
    output logic               err_overrun,
    input  logic [2:0]         tally_sel,
    output logic [TALLY_W-1:0] tally_out
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ROLLING, SETTLE, PRESENT} state_t;

    function automatic logic [6:0] pip_decode(input logic [2:0] face);
        case (face)
            3'd1:    pip_decode = 7'h08;
            3'd2:    pip_decode = 7'h41;
            3'd3:    pip_decode = 7'h49;
            3'd4:    pip_decode = 7'h63;
            3'd5:    pip_decode = 7'h6B;
            3'd6:    pip_decode = 7'h77;
            default: pip_decode = 7'h00;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic               button_prev_q, button_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         result_q, result_d;
    logic               valid_q, valid_d;
    logic [6:0]         pips_q, pips_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               err_inv_q, err_inv_d;
    logic               err_ovr_q, err_ovr_d;

    logic release_evt, face_ok, capture;

    assign release_evt = button_prev_q & ~button;
    assign face_ok     = (throw != 3'd0) && (throw != 3'd7);
    // A re-press during settling takes priority over the sample.
    assign capture     = (state_q == SETTLE) && !button && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            button_prev_q <= 1'b0;
            cnt_q         <= '0;
            result_q      <= '0;
            valid_q       <= 1'b0;
            pips_q        <= '0;
            count_q       <= '0;
            err_inv_q     <= 1'b0;
            err_ovr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            button_prev_q <= button_prev_d;
            cnt_q         <= cnt_d;
            result_q      <= result_d;
            valid_q       <= valid_d;
            pips_q        <= pips_d;
            count_q       <= count_d;
            err_inv_q     <= err_inv_d;
            err_ovr_q     <= err_ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (button) state_d = ROLLING;
            end
            ROLLING: begin
                if (release_evt) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (button)              state_d = ROLLING;
                else if (cnt_q == '0)    state_d = face_ok ? PRESENT : IDLE;
                else                     cnt_d   = cnt_q - 1'b1;
            end
            PRESENT: begin
                if (button)            state_d = ROLLING;
                else if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        button_prev_d = button;
        result_d      = (capture && face_ok) ? throw : result_q;
        count_d       = count_q;
        if (capture && face_ok && (count_q != '1))
            count_d = count_q + 1'b1;
        err_inv_d     = err_inv_q | (capture & ~face_ok);
        // Simultaneous ready completes the handshake, so no overrun then.
        err_ovr_d     = err_ovr_q | ((state_q == PRESENT) & button & ~result_ready);
        valid_d       = (state_d == PRESENT);
        pips_d        = ((state_d == ROLLING) || (state_d == SETTLE)) ?
                        pip_decode(throw) : pip_decode(result_d);
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign pips         = pips_q;
    assign roll_count   = count_q;
    assign err_invalid  = err_inv_q;
    assign err_overrun  = err_ovr_q;

`ifdef TALLY_EN
    logic [6*TALLY_W-1:0] tally_flat;

    for (genvar gi = 0; gi < 6; gi++) begin : g_tally
        logic [TALLY_W-1:0] tally_q, tally_d;

        always_comb begin
            tally_d = tally_q;
            if (capture && (throw == 3'(gi + 1)) && (tally_q != '1))
                tally_d = tally_q + 1'b1;
        end

        always_ff @(posedge clk) begin
            if (rst) tally_q <= '0;
            else     tally_q <= tally_d;
        end

        assign tally_flat[gi*TALLY_W +: TALLY_W] = tally_q;
    end

    always_comb begin
        tally_out = '0;
        for (int i = 0; i < 6; i++)
            if (tally_sel == 3'(i + 1))
                tally_out = tally_flat[i*TALLY_W +: TALLY_W];
    end
`else
    logic tally_sel_unused;
    assign tally_sel_unused = ^tally_sel;
    assign tally_out        = '0;
`endif

endmodule
